sd_fifo_cx: RTL and testbench

Compact flop-based srdy/drdy FIFO, the successor to the basic compact FIFO head, for any depth ≥ 2 including non-power-of-2.
- Adds a true full condition at `depth` entries (all `depth` entries usable).
- Adds a synchronous flush, almost-full / almost-empty flags, and a sticky overflow-attempt status bit.
- Sits between srdy/drdy pipeline stages wherever small, odd-sized elastic buffering is needed.

---
 rtl/sd_fifo_cx_if.sv | 22 ++
 rtl/sd_fifo_cx.sv | 105 ++++++++++
 tb/tb_sd_fifo_cx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_fifo_cx_if.sv
// srdy/drdy handshake bundle for sd_fifo_cx: consumer-side (c_*) input channel
// and producer-side (p_*) output channel. The FIFO uses the slave modport.
interface sd_fifo_cx_if #(
  parameter int width = 8
);
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;
  logic             p_srdy;
  logic             p_drdy;
  logic [width-1:0] p_data;

  modport master (
    output c_srdy, c_data, p_drdy,
    input  c_drdy, p_srdy, p_data
  );

  modport slave (
    input  c_srdy, c_data, p_drdy,
    output c_drdy, p_srdy, p_data
  );
endinterface

// File: rtl/sd_fifo_cx.sv
// Compact flop-based srdy/drdy FIFO for any depth >= 2, with flush, level flags
// and sticky overflow. Define SD_FIFO_CX_BYPASS_EN for zero-latency fall-through.
module sd_fifo_cx #(
  parameter int width      = 8,
  parameter int depth      = 6,
  parameter int usz        = $clog2(depth + 1),
  parameter int afull_lvl  = depth - 1,
  parameter int aempty_lvl = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  sd_fifo_cx_if.slave    bus,
  output logic [usz-1:0] usage,
  output logic           p_afull,
  output logic           c_aempty,
  output logic           ovf
);
  localparam int asz = $clog2(depth);

  logic [asz-1:0]   wrptr_reg, wrptr_next;
  logic [asz-1:0]   rdptr_reg, rdptr_next;
  logic [usz-1:0]   usage_reg, usage_next;
  logic             ovf_reg;
  logic [width-1:0] mem [depth];

  logic not_empty;
  logic not_full;
  logic wr;
  logic wr_mem;
  logic rd_mem;

  assign not_empty  = (usage_reg != '0);
  assign not_full   = (usage_reg != usz'(depth));
  assign bus.c_drdy = not_full;
  assign wr         = bus.c_srdy & not_full;
  assign rd_mem     = not_empty & bus.p_drdy;

`ifdef SD_FIFO_CX_BYPASS_EN
  logic byp;
  // An empty FIFO presents the incoming word directly; it is only stored
  // when the consumer does not take it in the same cycle.
  assign byp        = ~not_empty & bus.c_srdy;
  assign bus.p_srdy = not_empty | byp;
  assign bus.p_data = not_empty ? mem[rdptr_reg] : bus.c_data;
  assign wr_mem     = wr & ~(byp & bus.p_drdy);
`else
  assign bus.p_srdy = not_empty;
  assign bus.p_data = mem[rdptr_reg];
  assign wr_mem     = wr;
`endif

  // Storage entries are plain enabled flops; contents are never reset.
  generate
    for (genvar gi = 0; gi < depth; gi++) begin : g_entry
      logic [width-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (wr_mem && !flush && (wrptr_reg == asz'(gi)))
          entry_reg <= bus.c_data;
      end
      assign mem[gi] = entry_reg;
    end
  endgenerate

  // Explicit wrap at depth-1 keeps non-power-of-2 depths correct.
  always_comb begin
    wrptr_next = wrptr_reg;
    rdptr_next = rdptr_reg;
    usage_next = usage_reg;
    if (wr_mem)
      wrptr_next = (wrptr_reg == asz'(depth - 1)) ? '0 : wrptr_reg + 1'b1;
    if (rd_mem)
      rdptr_next = (rdptr_reg == asz'(depth - 1)) ? '0 : rdptr_reg + 1'b1;
    case ({wr_mem, rd_mem})
      2'b10:   usage_next = usage_reg + 1'b1;
      2'b01:   usage_next = usage_reg - 1'b1;
      default: usage_next = usage_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrptr_reg <= '0;
      rdptr_reg <= '0;
      usage_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (flush) begin
      wrptr_reg <= '0;
      rdptr_reg <= '0;
      usage_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      wrptr_reg <= wrptr_next;
      rdptr_reg <= rdptr_next;
      usage_reg <= usage_next;
      if (bus.c_srdy && !not_full)
        ovf_reg <= 1'b1;
    end
  end

  assign usage    = usage_reg;
  assign p_afull  = (usage_reg >= usz'(afull_lvl));
  assign c_aempty = (usage_reg <= usz'(aempty_lvl));
  assign ovf      = ovf_reg;
endmodule

// File: tb/tb_sd_fifo_cx.sv
// Scoreboard bench for sd_fifo_cx: directed full/stream/flush/reset scenarios
// followed by random traffic, with every cycle checked against a queue model.
module tb_sd_fifo_cx;
  localparam int WIDTH = 8;
  localparam int DEPTH = 6;
  localparam int USZ   = $clog2(DEPTH + 1);
`ifdef SD_FIFO_CX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk;
  logic           reset_n;
  logic           flush;
  logic [USZ-1:0] usage;
  logic           p_afull;
  logic           c_aempty;
  logic           ovf;

  sd_fifo_cx_if #(.width(WIDTH)) bus ();

  sd_fifo_cx #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .bus      (bus),
    .usage    (usage),
    .p_afull  (p_afull),
    .c_aempty (c_aempty),
    .ovf      (ovf)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] sb_q[$];
  bit ovf_exp = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle monitor: compare state against the model, then apply this cycle's handshakes.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb_q.delete();
      ovf_exp = 1'b0;
    end else begin
      bit full_m;
      bit psrdy_m;
      full_m  = (sb_q.size() == DEPTH);
      psrdy_m = (sb_q.size() != 0) || (BYP && bus.c_srdy);
      chk("usage", 32'(usage), 32'(sb_q.size()));
      chk("c_drdy", 32'(bus.c_drdy), 32'(!full_m));
      chk("p_srdy", 32'(bus.p_srdy), 32'(psrdy_m));
      chk("p_afull", 32'(p_afull), 32'(sb_q.size() >= DEPTH - 1));
      chk("c_aempty", 32'(c_aempty), 32'(sb_q.size() <= 1));
      chk("ovf", 32'(ovf), 32'(ovf_exp));
      if (flush) begin
        sb_q.delete();
        ovf_exp = 1'b0;
      end else begin
        if (bus.c_srdy && full_m) ovf_exp = 1'b1;
        if (bus.c_srdy && !full_m) sb_q.push_back(bus.c_data);
        if (bus.p_drdy && psrdy_m) begin
          if (sb_q.size() == 0) chk("underflow", 32'(bus.p_srdy), 32'(0));
          else chk("p_data", 32'(bus.p_data), 32'(sb_q.pop_front()));
        end
      end
    end
  end

  task automatic drain();
    bus.c_srdy = 1'b0;
    bus.p_drdy = 1'b1;
    for (int k = 0; k < 40 && usage != 0; k++) step();
    chk("drain_usage", 32'(usage), 32'(0));
    bus.p_drdy = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    flush      = 1'b0;
    bus.c_srdy = 1'b0;
    bus.c_data = '0;
    bus.p_drdy = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    chk("rst_p_srdy", 32'(bus.p_srdy), 32'(0));
    chk("rst_c_drdy", 32'(bus.c_drdy), 32'(1));
    chk("rst_aempty", 32'(c_aempty), 32'(1));
    chk("rst_afull", 32'(p_afull), 32'(0));
    chk("rst_usage", 32'(usage), 32'(0));
    step();

    // Fill to full, then attempt an extra write.
    for (int i = 0; i < DEPTH; i++) begin
      bus.c_srdy = 1'b1;
      bus.c_data = WIDTH'(8'h10 + i);
      step();
    end
    chk("full_usage", 32'(usage), 32'(DEPTH));
    chk("full_c_drdy", 32'(bus.c_drdy), 32'(0));
    chk("full_afull", 32'(p_afull), 32'(1));
    bus.c_data = 8'h99;
    step();
    chk("ovf_set", 32'(ovf), 32'(1));

    // Full with simultaneous read: the write is refused this cycle.
    bus.c_data = 8'h77;
    bus.p_drdy = 1'b1;
    step();
    chk("fullrd_usage", 32'(usage), 32'(DEPTH - 1));
    chk("fullrd_c_drdy", 32'(bus.c_drdy), 32'(1));
    drain();
    chk("drain_aempty", 32'(c_aempty), 32'(1));
    chk("ovf_sticky", 32'(ovf), 32'(1));

    // Continuous streaming across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      bus.c_srdy = 1'b1;
      bus.p_drdy = 1'b1;
      bus.c_data = WIDTH'(i);
      step();
      chk("stream_usage", 32'(usage), BYP ? 32'(0) : 32'(1));
    end
    drain();

    // Flush at usage 4 with both handshakes active.
    for (int i = 0; i < 4; i++) begin
      bus.c_srdy = 1'b1;
      bus.c_data = WIDTH'(8'h40 + i);
      step();
    end
    flush      = 1'b1;
    bus.c_data = 8'h55;
    bus.p_drdy = 1'b1;
    step();
    flush      = 1'b0;
    bus.p_drdy = 1'b0;
    chk("flush_usage", 32'(usage), 32'(0));
    chk("flush_p_srdy", 32'(bus.p_srdy), 32'(0));
    chk("flush_ovf", 32'(ovf), 32'(0));
    bus.c_data = 8'hAA;
    step();
    bus.c_srdy = 1'b0;
    chk("post_flush_head", 32'(bus.p_data), 32'(8'hAA));
    drain();

    // Latency / fall-through on an empty FIFO.
    bus.c_srdy = 1'b1;
    bus.c_data = 8'h5A;
    bus.p_drdy = 1'b1;
    #1;
`ifdef SD_FIFO_CX_BYPASS_EN
    chk("byp_p_srdy", 32'(bus.p_srdy), 32'(1));
    chk("byp_p_data", 32'(bus.p_data), 32'(8'h5A));
    step();
    bus.c_srdy = 1'b0;
    chk("byp_usage", 32'(usage), 32'(0));
`else
    chk("lat_p_srdy0", 32'(bus.p_srdy), 32'(0));
    step();
    bus.c_srdy = 1'b0;
    chk("lat_p_srdy1", 32'(bus.p_srdy), 32'(1));
    chk("lat_p_data", 32'(bus.p_data), 32'(8'h5A));
`endif
    drain();

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      bus.c_srdy = 1'b1;
      bus.p_drdy = (i == 2);
      bus.c_data = WIDTH'(8'h80 + i);
      step();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_p_srdy", 32'(bus.p_srdy), 32'(0));
    chk("arst_usage", 32'(usage), 32'(0));
    bus.c_srdy = 1'b0;
    bus.p_drdy = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      bus.c_srdy = 1'($urandom_range(0, 3) != 0);
      bus.p_drdy = 1'($urandom_range(0, 2) != 0);
      bus.c_data = WIDTH'($urandom);
      flush      = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;
    drain();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
